// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: operation encodings, Q16.16 constants and default widths.
// Imported by the result collector, its interface and the bench.
package cordic_pkg;

  localparam int CORDIC_DATA_W = 32;
  localparam int CORDIC_MODE_W = 4;

  typedef enum logic [CORDIC_MODE_W-1:0] {
    MODE_COS   = 4'd0,
    MODE_SIN   = 4'd1,
    MODE_ATAN  = 4'd2,
    MODE_COSH  = 4'd3,
    MODE_SINH  = 4'd4,
    MODE_ATANH = 4'd5,
    MODE_SQRT  = 4'd6,
    MODE_MUL   = 4'd7,
    MODE_DIV   = 4'd8
  } cordic_mode_e;

  localparam logic signed [CORDIC_DATA_W-1:0] Q16_ONE = 32'sd65536;

  // Ring pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cordic_result_collector_if.sv
// Host request, core request/result and host read-port signals of the result collector.
// The collector takes the slave view; the host/core environment takes the master view.
interface cordic_result_collector_if
  import cordic_pkg::*;
#(
  parameter int DATA_W = CORDIC_DATA_W,
  parameter int MODE_W = CORDIC_MODE_W,
  parameter int TAG_W  = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [MODE_W-1:0] in_mode;
  logic [DATA_W-1:0] in_angle;

  logic              core_pre_valid;
  logic [MODE_W-1:0] core_mode;
  logic [DATA_W-1:0] core_angle;
  logic              core_post_valid;
  logic [DATA_W-1:0] core_result;

  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [MODE_W-1:0] out_mode;
  logic [DATA_W-1:0] out_result;

  logic              err_orphan;

  modport slave (
    input  in_valid, in_mode, in_angle,
    input  core_post_valid, core_result,
    input  out_ready,
    output in_ready,
    output core_pre_valid, core_mode, core_angle,
    output out_valid, out_tag, out_mode, out_result,
    output err_orphan
  );

  modport master (
    output in_valid, in_mode, in_angle,
    output core_post_valid, core_result,
    output out_ready,
    input  in_ready,
    input  core_pre_valid, core_mode, core_angle,
    input  out_valid, out_tag, out_mode, out_result,
    input  err_orphan
  );

endinterface

// File: rtl/cordic_entry_ram.sv
// Entry ring storage: tag/mode written at issue, result written at completion,
// head entry read asynchronously.
module cordic_entry_ram #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 8,
  parameter int MODE_W = 4,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              tm_we,
  input  logic [AW-1:0]     tm_addr,
  input  logic [TAG_W-1:0]  tm_tag,
  input  logic [MODE_W-1:0] tm_mode,
  input  logic              res_we,
  input  logic [AW-1:0]     res_addr,
  input  logic [DATA_W-1:0] res_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [MODE_W-1:0] rd_mode,
  output logic [DATA_W-1:0] rd_result
);

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [MODE_W-1:0] mode_mem [DEPTH];
  logic [DATA_W-1:0] res_mem  [DEPTH];

  // Tag/mode and result live in separate arrays so both write ports never collide.
  always_ff @(posedge clk) begin
    if (tm_we) begin
      tag_mem[tm_addr]  <= tm_tag;
      mode_mem[tm_addr] <= tm_mode;
    end
    if (res_we) begin
      res_mem[res_addr] <= res_data;
    end
  end

  assign rd_tag    = tag_mem[rd_addr];
  assign rd_mode   = mode_mem[rd_addr];
  assign rd_result = res_mem[rd_addr];

endmodule

// File: rtl/cordic_result_collector.sv
// Issues host requests to an in-order CORDIC core, pairs each result with its tag/mode
// and buffers completed entries for a back-pressured host read port.
module cordic_result_collector
  import cordic_pkg::*;
#(
  parameter int DATA_W = CORDIC_DATA_W,
  parameter int MODE_W = CORDIC_MODE_W,
  parameter int TAG_W  = 8,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  cordic_result_collector_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_bits(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] CNT_FULL = PW'(DEPTH);

  logic [PW-1:0]     iptr_reg;
  logic [PW-1:0]     cptr_reg;
  logic [PW-1:0]     rptr_reg;
  logic [PW-1:0]     cnt_reg;
  logic [TAG_W-1:0]  seq_reg;
  logic              err_orphan_reg;
  logic              core_pre_valid_reg;
  logic [MODE_W-1:0] core_mode_reg;
  logic [DATA_W-1:0] core_angle_reg;

  logic              in_ready;
  logic              accept;
  logic              complete;
  logic              orphan;
  logic              out_valid;
  logic              pop;
  logic [TAG_W-1:0]  rd_tag;
  logic [MODE_W-1:0] rd_mode;
  logic [DATA_W-1:0] rd_result;

  // Space is reserved at accept, so a returning result always has an entry to land in.
  assign in_ready  = (cnt_reg != CNT_FULL);
  assign accept    = bus.in_valid & in_ready;
  assign complete  = bus.core_post_valid & (cptr_reg != iptr_reg);
  assign orphan    = bus.core_post_valid & (cptr_reg == iptr_reg);
  assign out_valid = (rptr_reg != cptr_reg);
  assign pop       = out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iptr_reg           <= '0;
      cptr_reg           <= '0;
      rptr_reg           <= '0;
      cnt_reg            <= '0;
      seq_reg            <= '0;
      err_orphan_reg     <= 1'b0;
      core_pre_valid_reg <= 1'b0;
      core_mode_reg      <= '0;
      core_angle_reg     <= '0;
    end else begin
      core_pre_valid_reg <= accept;
      if (accept) begin
        iptr_reg       <= iptr_reg + PTR_ONE;
        seq_reg        <= seq_reg + TAG_W'(1);
        core_mode_reg  <= bus.in_mode;
        core_angle_reg <= bus.in_angle;
      end
      if (complete) begin
        cptr_reg <= cptr_reg + PTR_ONE;
      end
      if (orphan) begin
        err_orphan_reg <= 1'b1;
      end
      if (pop) begin
        rptr_reg <= rptr_reg + PTR_ONE;
      end
      case ({accept, pop})
        2'b10:   cnt_reg <= cnt_reg + PTR_ONE;
        2'b01:   cnt_reg <= cnt_reg - PTR_ONE;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  cordic_entry_ram #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .MODE_W (MODE_W),
    .DATA_W (DATA_W)
  ) u_entry_ram (
    .clk       (clk),
    .tm_we     (accept),
    .tm_addr   (iptr_reg[AW-1:0]),
    .tm_tag    (seq_reg),
    .tm_mode   (bus.in_mode),
    .res_we    (complete),
    .res_addr  (cptr_reg[AW-1:0]),
    .res_data  (bus.core_result),
    .rd_addr   (rptr_reg[AW-1:0]),
    .rd_tag    (rd_tag),
    .rd_mode   (rd_mode),
    .rd_result (rd_result)
  );

  // Head fields read as zero when nothing is available, which also covers the reset state.
  assign bus.in_ready       = in_ready;
  assign bus.core_pre_valid = core_pre_valid_reg;
  assign bus.core_mode      = core_mode_reg;
  assign bus.core_angle     = core_angle_reg;
  assign bus.out_valid      = out_valid;
  assign bus.out_tag        = out_valid ? rd_tag    : '0;
  assign bus.out_mode       = out_valid ? rd_mode   : '0;
  assign bus.out_result     = out_valid ? rd_result : '0;
  assign bus.err_orphan     = err_orphan_reg;

endmodule
